// File: rtl/sad_min_select.sv
// Picks the minimum SAD, and where it occurred (lane, beat), across the beats of one search window.
// Results are held until the consumer takes them; protocol violations latch a sticky flag.
module sad_min_select #(
    parameter int PIXELS_IN_BATCH           = 16,
    parameter int INPUT_PSAD_BITS_PER_PIXEL = 14,
    parameter int ROW_BITS                  = 4,
    localparam int COL_BITS                 = $clog2(PIXELS_IN_BATCH)
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic [INPUT_PSAD_BITS_PER_PIXEL*PIXELS_IN_BATCH-1:0] psad_input,
    input  logic                                                 in_valid,
    input  logic                                                 in_first,
    input  logic                                                 in_last,
    output logic                                                 in_ready,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [INPUT_PSAD_BITS_PER_PIXEL-1:0]                 best_sad,
    output logic [COL_BITS-1:0]                                  best_col,
    output logic [ROW_BITS-1:0]                                  best_row,
    output logic                                                 protocol_err
);

    localparam int W = INPUT_PSAD_BITS_PER_PIXEL;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        run_sad_q, run_sad_d;
    logic [COL_BITS-1:0] run_col_q, run_col_d;
    logic [ROW_BITS-1:0] run_row_q, run_row_d;
    logic [ROW_BITS-1:0] cnt_q, cnt_d;
    logic [W-1:0]        best_sad_q, best_sad_d;
    logic [COL_BITS-1:0] best_col_q, best_col_d;
    logic [ROW_BITS-1:0] best_row_q, best_row_d;
    logic                perr_q, perr_d;

    logic [W-1:0]        beat_min;
    logic [COL_BITS-1:0] beat_col;
    logic                accept;
    logic                better;
    logic [W-1:0]        cand_sad;
    logic [COL_BITS-1:0] cand_col;
    logic [ROW_BITS-1:0] cand_row;

    // Strict less-than while scanning upward keeps the lowest lane on ties.
    always_comb begin
        beat_min = psad_input[W-1:0];
        beat_col = '0;
        for (int unsigned i = 1; i < PIXELS_IN_BATCH; i++) begin
            if (psad_input[i*W +: W] < beat_min) begin
                beat_min = psad_input[i*W +: W];
                beat_col = COL_BITS'(i);
            end
        end
    end

    assign in_ready = (state_q != HOLD);
    assign accept   = in_valid && in_ready;

    // A later beat must be strictly smaller to displace the running minimum.
    assign better   = (beat_min < run_sad_q);
    assign cand_sad = better ? beat_min : run_sad_q;
    assign cand_col = better ? beat_col : run_col_q;
    assign cand_row = better ? cnt_q    : run_row_q;

    always_comb begin
        state_d    = state_q;
        run_sad_d  = run_sad_q;
        run_col_d  = run_col_q;
        run_row_d  = run_row_q;
        cnt_d      = cnt_q;
        best_sad_d = best_sad_q;
        best_col_d = best_col_q;
        best_row_d = best_row_q;
        perr_d     = perr_q;
        case (state_q)
            IDLE, SCAN: begin
                if (accept) begin
                    if (in_first) begin
                        run_sad_d = beat_min;
                        run_col_d = beat_col;
                        run_row_d = '0;
                        cnt_d     = ROW_BITS'(1);
                        if (in_last) begin
                            best_sad_d = beat_min;
                            best_col_d = beat_col;
                            best_row_d = '0;
                            state_d    = HOLD;
                        end else begin
                            state_d = SCAN;
                        end
                    end else if (state_q == SCAN) begin
                        run_sad_d = cand_sad;
                        run_col_d = cand_col;
                        run_row_d = cand_row;
                        cnt_d     = cnt_q + ROW_BITS'(1);
                        if (cnt_q == '1) begin
                            perr_d = 1'b1;
                        end
                        if (in_last) begin
                            best_sad_d = cand_sad;
                            best_col_d = cand_col;
                            best_row_d = cand_row;
                            state_d    = HOLD;
                        end
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            run_sad_q  <= '1;
            run_col_q  <= '0;
            run_row_q  <= '0;
            cnt_q      <= '0;
            best_sad_q <= '1;
            best_col_q <= '0;
            best_row_q <= '0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_sad_q  <= run_sad_d;
            run_col_q  <= run_col_d;
            run_row_q  <= run_row_d;
            cnt_q      <= cnt_d;
            best_sad_q <= best_sad_d;
            best_col_q <= best_col_d;
            best_row_q <= best_row_d;
            perr_q     <= perr_d;
        end
    end

    assign out_valid    = (state_q == HOLD);
    assign best_sad     = best_sad_q;
    assign best_col     = best_col_q;
    assign best_row     = best_row_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_sad_min_select.sv
// Directed and randomized checks of sad_min_select against a window-level minimum-search model.
module tb_sad_min_select;

    localparam int P  = 16;
    localparam int W  = 14;
    localparam int RB = 4;
    localparam int CB = $clog2(P);

    typedef logic [W*P-1:0] psad_t;

    logic          clk = 1'b0;
    logic          rst_n;
    psad_t         psad_input;
    logic          in_valid, in_first, in_last, out_ready;
    logic          in_ready, out_valid, protocol_err;
    logic [W-1:0]  best_sad;
    logic [CB-1:0] best_col;
    logic [RB-1:0] best_row;

    int total = 0;
    int bad   = 0;

    psad_t win[$];
    int    exp_sad, exp_col, exp_row;

    sad_min_select #(
        .PIXELS_IN_BATCH(P),
        .INPUT_PSAD_BITS_PER_PIXEL(W),
        .ROW_BITS(RB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .psad_input(psad_input),
        .in_valid(in_valid),
        .in_first(in_first),
        .in_last(in_last),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .best_sad(best_sad),
        .best_col(best_col),
        .best_row(best_row),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic psad_t fill(input int v);
        psad_t b;
        for (int l = 0; l < P; l++) b[l*W +: W] = W'(v);
        return b;
    endfunction

    function automatic psad_t rand_beat();
        psad_t b;
        for (int l = 0; l < P; l++) begin
            if ($urandom_range(0, 3) == 0) b[l*W +: W] = W'($urandom_range(0, 16383));
            else                           b[l*W +: W] = W'($urandom_range(0, 15));
        end
        return b;
    endfunction

    // Expected result: global minimum of the window, then its earliest (row, lane) occurrence.
    task automatic model_best();
        int    mn;
        psad_t t;
        mn = 1 << W;
        foreach (win[r]) begin
            t = win[r];
            for (int l = 0; l < P; l++) if (int'(t[l*W +: W]) < mn) mn = int'(t[l*W +: W]);
        end
        exp_sad = mn;
        exp_row = -1;
        foreach (win[r]) begin
            t = win[r];
            for (int l = 0; l < P; l++) begin
                if (exp_row < 0 && int'(t[l*W +: W]) == mn) begin
                    exp_row = r;
                    exp_col = l;
                end
            end
        end
    endtask

    task automatic send_beat(input psad_t b, input logic f, input logic l);
        psad_input = b;
        in_first   = f;
        in_last    = l;
        in_valid   = 1'b1;
        if (f) win.delete();
        win.push_back(b);
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag);
        model_best();
        chk({tag, ".out_valid"}, 32'(out_valid), 1);
        chk({tag, ".best_sad"},  32'(best_sad),  exp_sad);
        chk({tag, ".best_col"},  32'(best_col),  exp_col);
        chk({tag, ".best_row"},  32'(best_row),  exp_row);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, ".ov_after_hs"}, 32'(out_valid), 0);
        chk({tag, ".rdy_after_hs"}, 32'(in_ready), 1);
    endtask

    initial begin
        psad_t b;
        int    n;
        rst_n      = 1'b0;
        psad_input = '0;
        in_valid   = 1'b0;
        in_first   = 1'b0;
        in_last    = 1'b0;
        out_ready  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.best_sad", 32'(best_sad), 32'h3FFF);
        chk("rst.best_col", 32'(best_col), 0);
        chk("rst.best_row", 32'(best_row), 0);
        chk("rst.perr", 32'(protocol_err), 0);
        chk("rst.in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        tick();

        // Single-beat window
        b = fill(100);
        b[5*W +: W] = W'(3);
        send_beat(b, 1'b1, 1'b1);
        check_result("single");
        chk("single.const_sad", 32'(best_sad), 3);
        chk("single.const_col", 32'(best_col), 5);
        handshake("single");

        // Four beats, tie across beats keeps the earlier one
        send_beat(fill(20), 1'b1, 1'b0);
        send_beat(fill(30), 1'b0, 1'b0);
        b = fill(200);
        b[9*W +: W] = W'(7);
        send_beat(b, 1'b0, 1'b0);
        chk("four.no_early_ov", 32'(out_valid), 0);
        b = fill(200);
        b[0 +: W] = W'(7);
        send_beat(b, 1'b0, 1'b1);
        check_result("four");
        chk("four.const_row", 32'(best_row), 2);
        chk("four.const_col", 32'(best_col), 9);
        handshake("four");

        // Back-pressure with a beat waiting at the input
        b = rand_beat();
        send_beat(b, 1'b1, 1'b1);
        model_best();
        psad_input = fill(0);
        in_valid   = 1'b1;
        in_first   = 1'b1;
        in_last    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold.in_ready", 32'(in_ready), 0);
            chk("hold.ov", 32'(out_valid), 1);
            chk("hold.sad", 32'(best_sad), exp_sad);
            chk("hold.col", 32'(best_col), exp_col);
            chk("hold.row", 32'(best_row), exp_row);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        chk("hold.ov_after_hs", 32'(out_valid), 0);
        chk("hold.rdy_after_hs", 32'(in_ready), 1);
        tick();
        chk("hold.no_accept_in_hs", 32'(out_valid), 0);

        // Restart mid-window discards the partial search
        b = fill(90);
        b[2*W +: W] = W'(1);
        send_beat(b, 1'b1, 1'b0);
        send_beat(fill(60), 1'b0, 1'b0);
        send_beat(fill(70), 1'b0, 1'b0);
        b = fill(80);
        b[11*W +: W] = W'(50);
        send_beat(b, 1'b1, 1'b0);
        send_beat(fill(55), 1'b0, 1'b1);
        check_result("restart");
        chk("restart.const_sad", 32'(best_sad), 50);
        handshake("restart");

        // Randomized windows with input gaps and output stalls
        for (int w = 0; w < 25; w++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                if (k > 0) begin
                    repeat ($urandom_range(0, 2)) begin
                        tick();
                        chk("rand.ov_gap", 32'(out_valid), 0);
                    end
                end
                send_beat(rand_beat(), k == 0, k == n - 1);
            end
            check_result("rand");
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("rand.ov_stall", 32'(out_valid), 1);
                chk("rand.sad_stall", 32'(best_sad), exp_sad);
            end
            handshake("rand");
        end
        chk("rand.perr_clean", 32'(protocol_err), 0);

        // Non-first beat in IDLE is a protocol error; later windows still work
        send_beat(fill(4), 1'b0, 1'b1);
        chk("idle_nf.ov", 32'(out_valid), 0);
        chk("idle_nf.perr", 32'(protocol_err), 1);
        send_beat(rand_beat(), 1'b1, 1'b0);
        send_beat(rand_beat(), 1'b0, 1'b1);
        check_result("after_err");
        chk("after_err.perr_sticky", 32'(protocol_err), 1);
        handshake("after_err");

        // Row counter overflow: the beat seen at counter 2^RB-1 flags an error
        rst_n = 1'b0;
        #1;
        chk("rst2.perr", 32'(protocol_err), 0);
        tick();
        rst_n = 1'b1;
        tick();
        b = fill(100);
        b[3*W +: W] = W'(1);
        send_beat(b, 1'b1, 1'b0);
        for (int k = 1; k < 16; k++) begin
            send_beat(fill(100), 1'b0, 1'b0);
            if (k == 14) chk("ovf.perr_before", 32'(protocol_err), 0);
        end
        chk("ovf.perr_after", 32'(protocol_err), 1);
        send_beat(fill(100), 1'b0, 1'b1);
        check_result("ovf");
        handshake("ovf");

        // Reset mid-scan: immediate reset values, aborted window never reported
        send_beat(fill(9), 1'b1, 1'b0);
        send_beat(fill(8), 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort.ov", 32'(out_valid), 0);
        chk("abort.sad", 32'(best_sad), 32'h3FFF);
        chk("abort.col", 32'(best_col), 0);
        chk("abort.row", 32'(best_row), 0);
        chk("abort.perr", 32'(protocol_err), 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("abort.ov_quiet", 32'(out_valid), 0);
        end
        send_beat(fill(2), 1'b0, 1'b1);
        chk("abort.nf_ignored", 32'(out_valid), 0);
        chk("abort.nf_perr", 32'(protocol_err), 1);
        tick();
        chk("abort.ov_final", 32'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
